// File: rtl/fault_map_pkg.sv
// Shared types for the fault map table.
//   error_t     : sweep classification of one word
//   fmt_state_t : table FSM states
//   entry_t     : one stored fault (word address + type)
package fault_map_pkg;

  localparam int FM_ADDR_W = 20;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_HIGH    = 2'b01,
    ERR_BOTH    = 2'b10,
    ERR_ILLEGAL = 2'b11
  } error_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RECORD = 2'b01,
    READY  = 2'b10,
    DUMP   = 2'b11
  } fmt_state_t;

  typedef struct packed {
    logic [FM_ADDR_W-1:0] addr;
    error_t               etype;
  } entry_t;

endpackage

// File: rtl/fault_map_table_if.sv
// Bus bundle for the fault map table: classification input stream, lookup
// request/response and the dump valid/ready stream.
//   slave  : the table side (fault_map_table)
//   master : the sweep / patch / dump consumer side
interface fault_map_table_if #(
  parameter int ADDR_W = 20
);
  // classification stream
  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [1:0]        in_error_type;
  logic              in_last;
  // lookup
  logic              lk_valid;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_resp_valid;
  logic              lk_hit;
  logic [1:0]        lk_error_type;
  // dump stream
  logic              dump_req;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [1:0]        dump_type;
  logic              dump_last;
  logic              dump_done;

  modport slave (
    input  in_valid, in_addr, in_error_type, in_last,
    input  lk_valid, lk_addr, dump_req, dump_ready,
    output lk_resp_valid, lk_hit, lk_error_type,
    output dump_valid, dump_addr, dump_type, dump_last, dump_done
  );

  modport master (
    output in_valid, in_addr, in_error_type, in_last,
    output lk_valid, lk_addr, dump_req, dump_ready,
    input  lk_resp_valid, lk_hit, lk_error_type,
    input  dump_valid, dump_addr, dump_type, dump_last, dump_done
  );
endinterface

// File: rtl/fault_map_cam.sv
// Entry storage for the fault map table with parallel address match.
//   clk, rst      : clock, synchronous active-high reset (clears valid bits)
//   clr           : empty the table (valid bits only)
//   lk_addr       : lookup match port  -> lk_hit, lk_type
//   dd_addr       : dedupe match port  -> dd_hit, dd_idx
//   wr_en/idx/entry : single write port, marks the slot valid
//   rd_idx        : indexed read for the dump stream -> rd_entry
module fault_map_cam
  import fault_map_pkg::*;
#(
  parameter int N_ENTRIES = 64,
  parameter int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [FM_ADDR_W-1:0] lk_addr,
  output logic                 lk_hit,
  output error_t               lk_type,
  input  logic [FM_ADDR_W-1:0] dd_addr,
  output logic                 dd_hit,
  output logic [IDX_W-1:0]     dd_idx,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  entry_t               wr_entry,
  input  logic [IDX_W-1:0]     rd_idx,
  output entry_t               rd_entry
);

  entry_t               mem [N_ENTRIES];
  logic [N_ENTRIES-1:0] vld;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld <= '0;
    end else if (wr_en) begin
      vld[wr_idx] <= 1'b1;
    end
  end

  // storage itself needs no reset: nothing reads a slot whose valid bit is 0
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_entry;
  end

  // Dedupe keeps addresses unique, so at most one slot matches either port.
  always_comb begin
    lk_hit  = 1'b0;
    lk_type = ERR_NONE;
    dd_hit  = 1'b0;
    dd_idx  = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (vld[i] && mem[i].addr == lk_addr) begin
        lk_hit  = 1'b1;
        lk_type = mem[i].etype;
      end
      if (vld[i] && mem[i].addr == dd_addr) begin
        dd_hit = 1'b1;
        dd_idx = IDX_W'(i);
      end
    end
  end

  assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/fault_map_table.sv
// Fault map table: records faulty words from the memory sweep, then serves
// 1-cycle lookups to the patch path and can dump its contents as a stream.
//   clk, rst          : clock, synchronous active-high reset
//   clear             : empty table and (re)enter RECORD
//   bus               : classification stream, lookup, dump stream
//   recording         : FSM in RECORD
//   table_ready       : FSM in READY or DUMP
//   n_entries         : number of valid entries
//   overflow          : sticky, a fault beat was dropped on a full table
//   illegal_seen      : sticky, a type-11 beat was received
//   count_high/both   : per-type fault beat counters
// Build option: define FAULT_MAP_COUNT_EN to build the per-type counters;
// otherwise count_high/count_both are tied to 0.
module fault_map_table
  import fault_map_pkg::*;
#(
  parameter int ADDR_W    = FM_ADDR_W,
  parameter int N_ENTRIES = 64,
  parameter int IDX_W     = $clog2(N_ENTRIES),
  parameter int CNT_W     = ADDR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  fault_map_table_if.slave     bus,
  output logic                 recording,
  output logic                 table_ready,
  output logic [IDX_W:0]       n_entries,
  output logic                 overflow,
  output logic                 illegal_seen,
  output logic [CNT_W-1:0]     count_high,
  output logic [CNT_W-1:0]     count_both
);

  fmt_state_t       state, state_nxt;
  logic [IDX_W-1:0] dump_idx;
  logic             lk_vld_q, lk_hit_q, dump_done_q;
  error_t           lk_type_q;

  error_t           in_type;
  logic             beat_en, store, full, dump_hs, dump_fin;
  logic             cam_lk_hit, cam_dd_hit, wr_en;
  error_t           cam_lk_type;
  logic [IDX_W-1:0] cam_dd_idx, wr_idx;
  entry_t           rd_entry;

  assign in_type = error_t'(bus.in_error_type);
  assign beat_en = (state == RECORD) && bus.in_valid && !clear;
  assign store   = (in_type == ERR_HIGH) || (in_type == ERR_BOTH);
  assign full    = (n_entries == (IDX_W+1)'(N_ENTRIES));

  // duplicates overwrite in place; new addresses append at n_entries
  assign wr_en  = beat_en && store && (cam_dd_hit || !full);
  assign wr_idx = cam_dd_hit ? cam_dd_idx : n_entries[IDX_W-1:0];

  fault_map_cam #(.N_ENTRIES(N_ENTRIES), .IDX_W(IDX_W)) u_cam (
    .clk      (clk),
    .rst      (rst),
    .clr      (clear),
    .lk_addr  (bus.lk_addr),
    .lk_hit   (cam_lk_hit),
    .lk_type  (cam_lk_type),
    .dd_addr  (bus.in_addr),
    .dd_hit   (cam_dd_hit),
    .dd_idx   (cam_dd_idx),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_entry ('{addr: bus.in_addr, etype: in_type}),
    .rd_idx   (dump_idx),
    .rd_entry (rd_entry)
  );

  // dump stream: outputs are a pure function of dump_idx, so they hold
  // steady for as long as the consumer stalls
  assign bus.dump_valid = (state == DUMP) && (n_entries != '0);
  assign bus.dump_last  = bus.dump_valid &&
                          ({1'b0, dump_idx} == n_entries - (IDX_W+1)'(1));
  assign bus.dump_addr  = bus.dump_valid ? rd_entry.addr : '0;
  assign bus.dump_type  = bus.dump_valid ? rd_entry.etype : ERR_NONE;
  assign dump_hs        = bus.dump_valid && bus.dump_ready;
  assign dump_fin       = (state == DUMP) && ((n_entries == '0) || (dump_hs && bus.dump_last));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = RECORD;
    end else begin
      case (state)
        RECORD:  if (bus.in_valid && bus.in_last) state_nxt = READY;
        READY:   if (bus.dump_req) state_nxt = DUMP;
        DUMP:    if (dump_fin) state_nxt = READY;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_entries    <= '0;
      overflow     <= 1'b0;
      illegal_seen <= 1'b0;
      dump_idx     <= '0;
      dump_done_q  <= 1'b0;
      lk_vld_q     <= 1'b0;
      lk_hit_q     <= 1'b0;
      lk_type_q    <= ERR_NONE;
    end else begin
      // lookup sees the table as it was before any same-cycle write
      lk_vld_q  <= bus.lk_valid;
      lk_hit_q  <= bus.lk_valid && table_ready && cam_lk_hit;
      lk_type_q <= (bus.lk_valid && table_ready && cam_lk_hit) ? cam_lk_type : ERR_NONE;
      dump_done_q <= 1'b0;
      if (clear) begin
        n_entries    <= '0;
        overflow     <= 1'b0;
        illegal_seen <= 1'b0;
        dump_idx     <= '0;
      end else begin
        if (beat_en) begin
          if (in_type == ERR_ILLEGAL) illegal_seen <= 1'b1;
          if (store && !cam_dd_hit) begin
            if (full) overflow  <= 1'b1;
            else      n_entries <= n_entries + (IDX_W+1)'(1);
          end
        end
        if (state == READY && bus.dump_req) dump_idx <= '0;
        if (dump_hs && !bus.dump_last)      dump_idx <= dump_idx + IDX_W'(1);
        dump_done_q <= dump_fin;
      end
    end
  end

`ifdef FAULT_MAP_COUNT_EN
  // counts every typed fault beat, including duplicates and dropped beats
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_high <= '0;
      count_both <= '0;
    end else if (beat_en) begin
      if (in_type == ERR_HIGH && count_high != '1) count_high <= count_high + CNT_W'(1);
      if (in_type == ERR_BOTH && count_both != '1) count_both <= count_both + CNT_W'(1);
    end
  end
`else
  assign count_high = '0;
  assign count_both = '0;
`endif

  assign bus.lk_resp_valid = lk_vld_q;
  assign bus.lk_hit        = lk_hit_q;
  assign bus.lk_error_type = lk_type_q;
  assign bus.dump_done     = dump_done_q;
  assign recording         = (state == RECORD);
  assign table_ready       = (state == READY) || (state == DUMP);

endmodule

// File: tb/tb_fault_map_table.sv
module tb_fault_map_table;

  localparam int ADDR_W = 20;
  localparam int NE     = 4;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = ADDR_W + 1;
`ifdef FAULT_MAP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic recording, table_ready, overflow, illegal_seen;
  logic [IDX_W:0]   n_entries;
  logic [CNT_W-1:0] count_high, count_both;

  fault_map_table_if #(.ADDR_W(ADDR_W)) bus ();

  fault_map_table #(.ADDR_W(ADDR_W), .N_ENTRIES(NE)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .bus          (bus),
    .recording    (recording),
    .table_ready  (table_ready),
    .n_entries    (n_entries),
    .overflow     (overflow),
    .illegal_seen (illegal_seen),
    .count_high   (count_high),
    .count_both   (count_both)
  );

  always #5 clk = ~clk;

  typedef struct { logic hit; logic [1:0] t; } lk_exp_t;
  typedef struct { logic [ADDR_W-1:0] a; logic [1:0] t; logic last; } dump_exp_t;

  lk_exp_t   lk_q[$];
  dump_exp_t dump_q[$];
  int n_chk = 0, n_fail = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [ADDR_W-1:0] a, input logic [1:0] t, input logic last);
    bus.in_valid = 1'b1; bus.in_addr = a; bus.in_error_type = t; bus.in_last = last;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic lookup(input logic [ADDR_W-1:0] a, input logic hit, input logic [1:0] t);
    lk_exp_t e;
    e.hit = hit; e.t = t;
    lk_q.push_back(e);
    bus.lk_valid = 1'b1; bus.lk_addr = a;
    tick();
    bus.lk_valid = 1'b0;
  endtask

  task automatic push_dump(input logic [ADDR_W-1:0] a, input logic [1:0] t, input logic last);
    dump_exp_t e;
    e.a = a; e.t = t; e.last = last;
    dump_q.push_back(e);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 20) begin tick(); k++; end
    check("dump_done_seen", done_cnt, target);
  endtask

  // scoreboard monitor: pops expectations whenever the DUT presents a response
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.lk_resp_valid) begin
        if (lk_q.size() == 0) check("lk_unexpected", 1, 0);
        else begin
          lk_exp_t e;
          e = lk_q.pop_front();
          check("lk_hit", bus.lk_hit, e.hit);
          check("lk_type", bus.lk_error_type, e.t);
        end
      end
      if (bus.dump_valid) begin
        if (dump_q.size() == 0) check("dump_unexpected", 1, 0);
        else begin
          dump_exp_t e;
          e = dump_q[0];
          if (bus.dump_ready) void'(dump_q.pop_front());
          check("dump_addr", bus.dump_addr, e.a);
          check("dump_type", bus.dump_type, e.t);
          check("dump_last", bus.dump_last, e.last);
        end
      end
      if (bus.dump_done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.in_valid = 0; bus.in_addr = '0; bus.in_error_type = '0; bus.in_last = 0;
    bus.lk_valid = 0; bus.lk_addr = '0; bus.dump_req = 0; bus.dump_ready = 0;
    tick(); tick();
    rst = 1'b0;
    // reset state
    check("rst_recording", recording, 0);
    check("rst_table_ready", table_ready, 0);
    check("rst_n_entries", n_entries, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dump_valid", bus.dump_valid, 0);
    check("rst_lk_resp", bus.lk_resp_valid, 0);

    // 1: record two faults
    do_clear();
    check("t1_recording", recording, 1);
    beat(20'h10, 2'b01, 0);
    beat(20'h11, 2'b00, 0);
    beat(20'h20, 2'b10, 0);
    beat(20'h30, 2'b00, 1);
    check("t1_table_ready", table_ready, 1);
    check("t1_recording_off", recording, 0);
    check("t1_n_entries", n_entries, 2);
    check("t1_overflow", overflow, 0);

    // 2: back-to-back lookups
    lookup(20'h20, 1, 2'b10);
    lookup(20'h11, 0, 2'b00);
    lookup(20'h10, 1, 2'b01);
    lookup(20'h99, 0, 2'b00);
    tick();

    // 5: dump with a 3-cycle stall
    push_dump(20'h10, 2'b01, 0);
    push_dump(20'h20, 2'b10, 1);
    d0 = done_cnt;
    bus.dump_req = 1; tick(); bus.dump_req = 0;
    tick(); tick(); tick();
    bus.dump_ready = 1;
    wait_done(d0 + 1);
    bus.dump_ready = 0;
    tick(); tick();
    check("t5_done_once", done_cnt, d0 + 1);
    check("t5_dump_drained", dump_q.size(), 0);
    check("t5_back_ready", table_ready, 1);

    // empty table dump: no beats, one done pulse
    do_clear();
    beat(20'h5, 2'b00, 1);
    check("t5e_n_entries", n_entries, 0);
    d0 = done_cnt;
    bus.dump_req = 1; tick(); bus.dump_req = 0;
    wait_done(d0 + 1);
    check("t5e_table_ready", table_ready, 1);

    // 3: overflow on a 4-entry table
    do_clear();
    beat(20'h100, 2'b01, 0);
    beat(20'h101, 2'b10, 0);
    lookup(20'h100, 0, 2'b00);   // RECORD: no hits reported
    beat(20'h102, 2'b01, 0);
    beat(20'h103, 2'b10, 0);
    beat(20'h104, 2'b01, 0);
    beat(20'h105, 2'b10, 1);
    check("t3_n_entries", n_entries, 4);
    check("t3_overflow", overflow, 1);
    check("t3_count_high", count_high, CNT_EN ? 3 : 0);
    check("t3_count_both", count_both, CNT_EN ? 3 : 0);
    lookup(20'h103, 1, 2'b10);
    lookup(20'h104, 0, 2'b00);
    lookup(20'h100, 1, 2'b01);

    // 4: duplicate address overwrites type
    do_clear();
    check("t4_overflow_cleared", overflow, 0);
    beat(20'h40, 2'b01, 0);
    beat(20'h40, 2'b10, 1);
    check("t4_n_entries", n_entries, 1);
    check("t4_count_high", count_high, CNT_EN ? 1 : 0);
    check("t4_count_both", count_both, CNT_EN ? 1 : 0);
    lookup(20'h40, 1, 2'b10);

    // 6: clear aborts a dump; illegal beat
    do_clear();
    beat(20'h10, 2'b01, 0);
    beat(20'h20, 2'b10, 1);
    push_dump(20'h10, 2'b01, 0);
    bus.dump_req = 1; tick(); bus.dump_req = 0;
    tick();
    d0 = done_cnt;
    do_clear();
    dump_q.delete();
    check("t6_recording", recording, 1);
    check("t6_n_entries", n_entries, 0);
    check("t6_table_ready", table_ready, 0);
    tick(); tick(); tick();
    check("t6_no_done", done_cnt, d0);
    beat(20'h77, 2'b11, 1);
    check("t6_illegal", illegal_seen, 1);
    check("t6_n_entries_after", n_entries, 0);
    check("t6_count_both", count_both, 0);
    lookup(20'h77, 0, 2'b00);
    tick(); tick();
    check("end_lk_drained", lk_q.size(), 0);
    check("end_dump_drained", dump_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
